// File: rtl/sme_feeder.sv
// Host-side initiator for the SME string-match engine: buffers one string and one
// pattern, streams them to SME, waits for a result and hands it back to the host.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err,
  output logic       res_timeout,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    STR_MAX_L = 6'(STR_MAX);
  localparam logic [3:0]    PAT_MAX_L = 4'(PAT_MAX);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STR  = 3'd1,
    S_PAT  = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    str_len_q, str_len_d;
  logic [3:0]    pat_len_q, pat_len_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          res_match_q, res_match_d;
  logic [4:0]    res_index_q, res_index_d;
  logic          res_err_q, res_err_d;
  logic          res_timeout_q, res_timeout_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          isstring_q, isstring_d;
  logic          ispattern_q, ispattern_d;

  logic [7:0]    str_buf_q [STR_MAX];
  logic [7:0]    pat_buf_q [PAT_MAX];

  logic [5:0]    eff_str_s;
  logic [3:0]    eff_pat_s;
  logic          len_err_s;

  // Buffers carry no reset so host data survives an aborted transaction.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) begin
        pat_buf_q[wr_addr[2:0]] <= wr_data;
      end else begin
        str_buf_q[wr_addr] <= wr_data;
      end
    end
  end

  // Clamp requested lengths and flag transactions that have nothing to send.
  always_comb begin
    eff_str_s = (str_len > STR_MAX_L) ? STR_MAX_L : str_len;
    eff_pat_s = (pat_len > PAT_MAX_L) ? PAT_MAX_L : pat_len;
    len_err_s = (eff_pat_s == 4'd0) || (send_str && (eff_str_s == 6'd0));
  end

  // Next-state and registered-output logic; strobes are computed for the
  // upcoming cycle so each character leaves straight from a flop.
  always_comb begin
    state_d       = state_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    chardata_d    = 8'd0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          str_len_d     = eff_str_s;
          pat_len_d     = eff_pat_s;
          busy_d        = 1'b1;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b0;
          idx_d         = 6'd1;
          if (len_err_s) begin
            state_d   = S_FIN;
            res_err_d = 1'b1;
          end else if (send_str) begin
            state_d    = S_STR;
            isstring_d = 1'b1;
            chardata_d = str_buf_q[0];
          end else begin
            state_d     = S_PAT;
            ispattern_d = 1'b1;
            chardata_d  = pat_buf_q[0];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STR: begin
        if (idx_q == str_len_q) begin
          state_d     = S_PAT;
          ispattern_d = 1'b1;
          chardata_d  = pat_buf_q[0];
          idx_d       = 6'd1;
        end else begin
          isstring_d = 1'b1;
          chardata_d = str_buf_q[idx_q[4:0]];
          idx_d      = idx_q + 6'd1;
        end
      end
      S_PAT: begin
        if (idx_q == {2'b00, pat_len_q}) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          ispattern_d = 1'b1;
          chardata_d  = pat_buf_q[idx_q[2:0]];
          idx_d       = idx_q + 6'd1;
        end
      end
      S_WAIT: begin
        // A valid in the final allowed cycle still wins over the timeout.
        if (valid) begin
          res_match_d = match;
          res_index_d = match_index;
          state_d     = S_FIN;
        end else if (cnt_q == TO_LAST) begin
          res_timeout_d = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          state_d       = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      str_len_q     <= 6'd0;
      pat_len_q     <= 4'd0;
      idx_q         <= 6'd0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      chardata_q    <= 8'd0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_timeout_q;
  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: the bench plays host and SME, and checks
// character streams, latencies and result capture against hand-computed values.
module tb_sme_feeder;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       send_str;
  logic       start;
  logic       busy;
  logic       done;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       res_timeout;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sbuf [0:39];
  logic [7:0] pbuf [0:39];
  int nstr, npat, done_cyc, first_str;
  logic both_hi, dirty, saw_done;

  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .send_str(send_str),
    .start(start), .busy(busy), .done(done), .res_match(res_match),
    .res_index(res_index), .res_err(res_err), .res_timeout(res_timeout),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // vdel: WAIT cycle (1-based) in which the SME model raises valid; -1 = never.
  task automatic run(input logic snd, input logic [5:0] sl, input logic [3:0] pl,
                     input int vdel, input logic m, input logic [4:0] mi, input logic bwr);
    int wn;
    nstr = 0; npat = 0; done_cyc = -1; first_str = -1; both_hi = 1'b0; dirty = 1'b0; wn = 0;
    match = m; match_index = mi; send_str = snd; str_len = sl; pat_len = pl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      valid = 1'b0; wr_en = 1'b0;
      if (isstring && ispattern) both_hi = 1'b1;
      if (isstring) begin
        if (first_str < 0) first_str = c;
        if (nstr < 40) sbuf[nstr] = chardata;
        nstr++;
      end
      if (ispattern) begin
        if (npat < 40) pbuf[npat] = chardata;
        npat++;
      end
      if (!isstring && !ispattern && chardata != 8'd0) dirty = 1'b1;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!isstring && !ispattern && npat > 0) begin
        wn++;
        if (wn == vdel) valid = 1'b1;
      end
      if (bwr && c == 3) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h5A;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'd0;
    str_len = 6'd0; pat_len = 4'd0; send_str = 1'b0; start = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
    #3;
    chk("reset_outputs", {busy, done, isstring, ispattern, chardata, res_match,
                          res_index, res_err, res_timeout}, 32'd0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;

    // T1: string "ABCAB", pattern "CAB", SME answers match at index 2
    wr(1'b0, 5'd0, 8'h41); wr(1'b0, 5'd1, 8'h42); wr(1'b0, 5'd2, 8'h43);
    wr(1'b0, 5'd3, 8'h41); wr(1'b0, 5'd4, 8'h42);
    wr(1'b1, 5'd0, 8'h43); wr(1'b1, 5'd1, 8'h41); wr(1'b1, 5'd2, 8'h42);
    run(1'b1, 6'd5, 4'd3, 2, 1'b1, 5'd2, 1'b0);
    chk("t1_first_str_cyc", first_str, 32'd1);
    chk("t1_nstr", nstr, 32'd5);
    chk("t1_str_chars", {sbuf[0], sbuf[1], sbuf[2], sbuf[3]}, 32'h41424341);
    chk("t1_str_char4", sbuf[4], 32'h42);
    chk("t1_npat", npat, 32'd3);
    chk("t1_pat_chars", {8'd0, pbuf[0], pbuf[1], pbuf[2]}, 32'h00434142);
    chk("t1_done_cyc", done_cyc, 32'd12);
    chk("t1_res", {busy, res_match, res_index, res_err, res_timeout}, {27'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0} >> 0);
    chk("t1_both_hi", both_hi, 32'd0);
    chk("t1_idle_data", dirty, 32'd0);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", done, 32'd0);

    // T2: pattern-only transaction reusing the string SME holds
    wr(1'b1, 5'd0, 8'h58); wr(1'b1, 5'd1, 8'h59);
    run(1'b0, 6'd5, 4'd2, 1, 1'b0, 5'd0, 1'b0);
    chk("t2_nstr", nstr, 32'd0);
    chk("t2_npat", npat, 32'd2);
    chk("t2_pat_chars", {pbuf[0], pbuf[1]}, 32'h5859);
    chk("t2_done_cyc", done_cyc, 32'd5);
    chk("t2_res", {res_match, res_index, res_err, res_timeout}, 32'd0);

    // T3: oversize lengths clamp to 32 and 8
    for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) wr(1'b1, 5'(i), 8'h60 + 8'(i));
    run(1'b1, 6'd40, 4'd12, 1, 1'b1, 5'd31, 1'b0);
    chk("t3_nstr", nstr, 32'd32);
    chk("t3_npat", npat, 32'd8);
    for (int i = 0; i < 32; i++) begin
      e = 8'h40 + 8'(i);
      chk($sformatf("t3_str%0d", i), sbuf[i], {24'd0, e});
    end
    for (int i = 0; i < 8; i++) begin
      e = 8'h60 + 8'(i);
      chk($sformatf("t3_pat%0d", i), pbuf[i], {24'd0, e});
    end
    chk("t3_done_cyc", done_cyc, 32'd43);
    chk("t3_res", {res_match, res_index}, {26'd0, 1'b1, 5'd31});

    // T4: zero pattern length, then zero string length with send_str=1
    run(1'b1, 6'd5, 4'd0, -1, 1'b0, 5'd0, 1'b0);
    chk("t4_done_cyc", done_cyc, 32'd2);
    chk("t4_traffic", nstr + npat, 32'd0);
    chk("t4_res", {res_match, res_index, res_err, res_timeout}, {24'd0, 1'b1, 5'd31, 1'b1, 1'b0});
    run(1'b1, 6'd0, 4'd3, -1, 1'b0, 5'd0, 1'b0);
    chk("t4b_done_cyc", done_cyc, 32'd2);
    chk("t4b_traffic", nstr + npat, 32'd0);
    chk("t4b_err", res_err, 32'd1);

    // T5: SME never answers; a host write while busy must be dropped
    run(1'b1, 6'd5, 4'd3, -1, 1'b1, 5'd9, 1'b1);
    chk("t5_nstr", nstr, 32'd5);
    chk("t5_npat", npat, 32'd3);
    chk("t5_done_cyc", done_cyc, 32'd26);
    chk("t5_res", {res_match, res_index, res_err, res_timeout}, 32'd1);

    // T6: reset during the third string character, then a clean rerun
    send_str = 1'b1; str_len = 6'd5; pat_len = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_third_char", {isstring, chardata}, {23'd0, 1'b1, 8'h42});
    reset = 1'b0;
    #1;
    chk("t6_async_drop", {busy, isstring, ispattern, chardata}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || isstring || ispattern) saw_done = 1'b1;
    end
    chk("t6_no_done", saw_done, 32'd0);
    run(1'b1, 6'd5, 4'd3, 1, 1'b1, 5'd4, 1'b0);
    chk("t6_nstr", nstr, 32'd5);
    chk("t6_str_chars", {sbuf[0], sbuf[1], sbuf[2], sbuf[3]}, 32'h40414243);
    chk("t6_str_char4", sbuf[4], 32'h44);
    chk("t6_pat_chars", {8'd0, pbuf[0], pbuf[1], pbuf[2]}, 32'h00606162);
    chk("t6_done_cyc", done_cyc, 32'd11);
    chk("t6_res", {res_match, res_index, res_err, res_timeout}, {24'd0, 1'b1, 5'd4, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Hardware initiator for the SME string-match engine: holds one string (up to 32 chars) and one pattern (up to 8 chars) loaded by a host, streams them to SME on chardata/isstring/ispattern, waits for valid, and returns match/match_index to the host.
- Sits between the host/control logic and SME. It replaces the file-driven stimulus used in simulation, so SME can be exercised on-chip and in system-level benches.

Parameters:
- STR_MAX, 32, string buffer depth; also the maximum effective str_len.
- PAT_MAX, 8, pattern buffer depth; also the maximum effective pat_len.
- TIMEOUT, 1024, number of WAIT cycles without valid before the block aborts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer.
- wr_addr  in  5  buffer address; pattern buffer uses bits [2:0].
- wr_data  in  8  character to write.
- str_len  in  6  string length; sampled at start.
- pat_len  in  4  pattern length; sampled at start.
- send_str  in  1  1 = send string then pattern; 0 = pattern only, reusing the string SME already holds.
- start  in  1  begin a transaction; one-cycle pulse.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the result is valid.
- res_match  out  1  captured SME match.
- res_index  out  5  captured SME match_index.
- res_err  out  1  transaction rejected because of a zero length.
- res_timeout  out  1  valid not seen within TIMEOUT cycles.
- chardata  out  8  character to SME.
- isstring  out  1  string character strobe to SME.
- ispattern  out  1  pattern character strobe to SME.
- valid  in  1  SME result valid.
- match  in  1  SME match flag.
- match_index  in  5  SME match position.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - Buffer contents are not reset.
  - Reset mid-transaction aborts the transaction silently: no done pulse, and SME strobes drop at once.
- FSM states: IDLE, STR, PAT, WAIT, FIN. All outputs are registered.
- Host writes:
  - Accepted only in IDLE; wr_en is ignored while busy=1.
  - A write accepted in cycle N is visible to a start issued in cycle N+1.
- Length handling at start:
  - Effective lengths: str_len values above 32 clamp to 32; pat_len values above 8 clamp to 8.
  - If eff_pat_len==0, or send_str=1 and eff_str_len==0: go to FIN with res_err=1. No SME traffic is generated.
- IDLE:
  - start=1 latches lengths and send_str and sets busy=1 on the next edge.
  - Next state is STR if send_str=1, otherwise PAT.
  - start is ignored while busy=1.
- STR:
  - Each cycle drives isstring=1 and chardata=str_buf[k], for k=0..eff_str_len-1, one character per cycle with no gaps.
  - After the last character, moves directly to PAT. The first pattern character follows in the next cycle.
- PAT:
  - Each cycle drives ispattern=1 and chardata=pat_buf[k], for k=0..eff_pat_len-1.
  - isstring and ispattern are never high together.
- WAIT:
  - isstring=0, ispattern=0, chardata=0; the timeout counter increments each cycle.
  - valid=1 sampled: capture match and match_index into res_match/res_index, then go to FIN.
  - Counter reaches TIMEOUT: res_timeout=1, res_match=0, res_index=0, then go to FIN.
  - valid seen during STR or PAT is ignored.
- FIN:
  - One cycle with done=1 and busy=0, then IDLE.
  - res_* outputs hold their values until the next start, which clears res_err and res_timeout.
- Latency with send_str=1: first isstring appears 1 cycle after start. done appears eff_str_len + eff_pat_len + W + 2 cycles after start, where W = number of WAIT cycles up to and including the valid cycle.

Test Plan:
- Load string "ABCAB", pattern "CAB"; str_len=5, pat_len=3, send_str=1; start; SME model asserts valid with match=1, index=2 → 5 consecutive isstring cycles (A,B,C,A,B), then 3 ispattern cycles (C,A,B), then done with res_match=1, res_index=2, busy low.
- Follow-on transaction: pattern "XY", send_str=0, pat_len=2; SME returns match=0 → no isstring, 2 ispattern cycles, done with res_match=0, res_err=0.
- str_len=40, pat_len=12 → exactly 32 isstring cycles and 8 ispattern cycles; addresses wrap no further than 31 and 7.
- pat_len=0 with start → done 2 cycles after start with res_err=1; isstring and ispattern never asserted.
- TIMEOUT=16, SME never asserts valid → done 16 WAIT cycles after the last ispattern, with res_timeout=1.
- Assert reset during the third isstring cycle → isstring drops asynchronously, no done pulse; a new start afterwards completes normally using the unchanged buffer contents.
